// File: rtl/riscv_control_fsm.sv
// Multicycle RV32I control FSM: fetch/decode/execute sequencing with memory wait-state timing.
// Optional PAUSE_EN macro adds a single-step pause at every instruction boundary.
module riscv_control_fsm #(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       run_i,
  input  logic       continue_i,
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  input  logic       br_sig_i,
  output logic       ld_mar_o,
  output logic       ld_mdr_o,
  output logic       ld_ir_o,
  output logic       ld_pc_o,
  output logic       ld_led_o,
  output logic       reg_w_en_o,
  output logic       a_sel_o,
  output logic       b_sel_o,
  output logic       marmux_sel_o,
  output logic       pcmux_sel_o,
  output logic [1:0] writeback_sel_o,
  output logic [3:0] alu_sel_o,
  output logic       mem_rd_o,
  output logic       mem_wr_o,
  output logic       illegal_o,
  output logic [4:0] state_dbg_o
);

  typedef enum logic [4:0] {
    StHalt     = 5'd0,
    StFetch1   = 5'd1,
    StFetch2   = 5'd2,
    StFetch3   = 5'd3,
    StDecode   = 5'd4,
    StRAlu     = 5'd5,
    StIAlu     = 5'd6,
    StLwAddr   = 5'd7,
    StLwWb     = 5'd8,
    StSwMem    = 5'd9,
    StBrCmp    = 5'd10,
    StBrTgt    = 5'd11,
    StJal      = 5'd12,
    StJalr     = 5'd13,
    StAuipc    = 5'd14,
    StTrap     = 5'd15,
    StPause    = 5'd16,
    StPauseRel = 5'd17
  } state_e;

  localparam logic [3:0] WaitLast = 4'(MEM_WAIT - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       taken_q, taken_d;
  logic       illegal_q, illegal_d;
  logic       cnt_last;
  logic       br_ok;
  logic [3:0] br_alu;
  state_e     boundary_st;

  logic unused_inputs;
`ifdef PAUSE_EN
  assign unused_inputs = ^{funct7_i[6], funct7_i[4:0]};
`else
  assign unused_inputs = ^{funct7_i[6], funct7_i[4:0], continue_i};
`endif

  function automatic logic [3:0] alu_map(input logic [2:0] f3, input logic alt,
                                         input logic allow_sub);
    logic [3:0] op;
    unique case (f3)
      3'b000:  op = (allow_sub && alt) ? 4'd1 : 4'd0;
      3'b001:  op = 4'd2;
      3'b010:  op = 4'd3;
      3'b011:  op = 4'd4;
      3'b100:  op = 4'd5;
      3'b101:  op = alt ? 4'd7 : 4'd6;
      3'b110:  op = 4'd8;
      default: op = 4'd9;
    endcase
    return op;
  endfunction

  function automatic logic is_mem(input state_e st);
    return (st == StFetch2) || (st == StLwAddr) || (st == StSwMem);
  endfunction

  assign cnt_last = (cnt_q == 4'd0);

  always_comb begin
    br_ok  = 1'b1;
    br_alu = 4'd0;
    unique case (funct3_i)
      3'b000:  br_alu = 4'hA;
      3'b001:  br_alu = 4'hB;
      3'b100:  br_alu = 4'hC;
      3'b101:  br_alu = 4'hD;
      3'b110:  br_alu = 4'hE;
      3'b111:  br_alu = 4'hF;
      default: br_ok  = 1'b0;
    endcase
  end

`ifdef PAUSE_EN
  assign boundary_st = StPause;
`else
  assign boundary_st = run_i ? StFetch1 : StHalt;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StHalt:   if (run_i) state_d = StFetch1;
      StFetch1: state_d = StFetch2;
      StFetch2: if (cnt_last) state_d = StFetch3;
      StFetch3: state_d = StDecode;
      StDecode: begin
        unique case (opcode_i)
          7'h33:   state_d = StRAlu;
          7'h13:   state_d = StIAlu;
          7'h03:   state_d = StLwAddr;
          7'h23:   state_d = StSwMem;
          7'h63:   state_d = StBrCmp;
          7'h6F:   state_d = StJal;
          7'h67:   state_d = StJalr;
          7'h17:   state_d = StAuipc;
          default: state_d = StTrap;
        endcase
      end
      StRAlu, StIAlu, StLwWb, StBrTgt, StJal, StJalr, StAuipc: state_d = boundary_st;
      StLwAddr: if (cnt_last) state_d = StLwWb;
      StSwMem:  if (cnt_last) state_d = boundary_st;
      StBrCmp:  state_d = br_ok ? StBrTgt : StTrap;
      StTrap:   state_d = StTrap;
`ifdef PAUSE_EN
      StPause:    if (continue_i) state_d = StPauseRel;
      StPauseRel: if (!continue_i) state_d = run_i ? StFetch1 : StHalt;
`endif
      default:  state_d = StHalt;
    endcase
  end

  // Counter reloads on entry to a memory state and counts down to the last strobe cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (is_mem(state_d) && (state_d != state_q)) begin
      cnt_d = WaitLast;
    end else if (is_mem(state_q) && !cnt_last) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  assign taken_d   = (state_q == StBrCmp) ? br_sig_i : taken_q;
  assign illegal_d = illegal_q | (state_d == StTrap);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StHalt;
      cnt_q     <= 4'd0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      taken_q   <= taken_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    ld_mar_o        = 1'b0;
    ld_mdr_o        = 1'b0;
    ld_ir_o         = 1'b0;
    ld_pc_o         = 1'b0;
    ld_led_o        = 1'b0;
    reg_w_en_o      = 1'b0;
    a_sel_o         = 1'b0;
    b_sel_o         = 1'b0;
    marmux_sel_o    = 1'b0;
    pcmux_sel_o     = 1'b0;
    writeback_sel_o = 2'd0;
    alu_sel_o       = 4'd0;
    mem_rd_o        = 1'b0;
    mem_wr_o        = 1'b0;
    unique case (state_q)
      StFetch1: ld_mar_o = 1'b1;
      StFetch2: begin
        mem_rd_o = 1'b1;
        ld_mdr_o = cnt_last;
      end
      StFetch3: ld_ir_o = 1'b1;
      StRAlu: begin
        alu_sel_o       = alu_map(funct3_i, funct7_i[5], 1'b1);
        writeback_sel_o = 2'd1;
        reg_w_en_o      = 1'b1;
        ld_pc_o         = 1'b1;
      end
      StIAlu: begin
        b_sel_o         = 1'b1;
        alu_sel_o       = alu_map(funct3_i, funct7_i[5], 1'b0);
        writeback_sel_o = 2'd1;
        reg_w_en_o      = 1'b1;
        ld_pc_o         = 1'b1;
      end
      StLwAddr: begin
        b_sel_o  = 1'b1;
        mem_rd_o = 1'b1;
      end
      StLwWb: begin
        reg_w_en_o = 1'b1;
        ld_pc_o    = 1'b1;
      end
      StSwMem: begin
        b_sel_o  = 1'b1;
        mem_wr_o = 1'b1;
        ld_pc_o  = cnt_last;
      end
      StBrCmp: alu_sel_o = br_alu;
      StBrTgt: begin
        a_sel_o     = 1'b1;
        b_sel_o     = 1'b1;
        ld_pc_o     = 1'b1;
        pcmux_sel_o = taken_q;
      end
      StJal, StJalr: begin
        a_sel_o         = (state_q == StJal);
        b_sel_o         = 1'b1;
        pcmux_sel_o     = 1'b1;
        ld_pc_o         = 1'b1;
        writeback_sel_o = 2'd2;
        reg_w_en_o      = 1'b1;
      end
      StAuipc: begin
        a_sel_o         = 1'b1;
        b_sel_o         = 1'b1;
        writeback_sel_o = 2'd1;
        reg_w_en_o      = 1'b1;
        ld_pc_o         = 1'b1;
      end
`ifdef PAUSE_EN
      StPause: ld_led_o = 1'b1;
`endif
      default: ;
    endcase
  end

  assign illegal_o   = illegal_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_riscv_control_fsm.sv
// Directed, table-driven bench for riscv_control_fsm (default build, MEM_WAIT=2).
module tb_riscv_control_fsm;

  localparam logic [4:0] SHalt = 5'd0, SF1 = 5'd1, SF2 = 5'd2, SF3 = 5'd3, SDec = 5'd4;
  localparam logic [4:0] SRAlu = 5'd5, SIAlu = 5'd6, SLwA = 5'd7, SLwWb = 5'd8, SSw = 5'd9;
  localparam logic [4:0] SBrC = 5'd10, SBrT = 5'd11, SJal = 5'd12, SJalr = 5'd13;
  localparam logic [4:0] SAuipc = 5'd14, STrap = 5'd15;

  logic       clk = 1'b0;
  logic       rst, run, cont, br;
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic       ld_mar, ld_mdr, ld_ir, ld_pc, ld_led, regw, a_sel, b_sel, marmux, pcmux;
  logic [1:0] wb;
  logic [3:0] alu;
  logic       mem_rd, mem_wr, illegal;
  logic [4:0] state_dbg;
  logic [23:0] obs;

  int total = 0;
  int passed = 0;

  riscv_control_fsm #(.MEM_WAIT(2)) dut (
    .clk_i(clk), .rst_i(rst), .run_i(run), .continue_i(cont),
    .opcode_i(op), .funct3_i(f3), .funct7_i(f7), .br_sig_i(br),
    .ld_mar_o(ld_mar), .ld_mdr_o(ld_mdr), .ld_ir_o(ld_ir), .ld_pc_o(ld_pc),
    .ld_led_o(ld_led), .reg_w_en_o(regw), .a_sel_o(a_sel), .b_sel_o(b_sel),
    .marmux_sel_o(marmux), .pcmux_sel_o(pcmux), .writeback_sel_o(wb), .alu_sel_o(alu),
    .mem_rd_o(mem_rd), .mem_wr_o(mem_wr), .illegal_o(illegal), .state_dbg_o(state_dbg)
  );

  always #5 clk = ~clk;

  assign obs = {state_dbg, ld_mar, ld_mdr, ld_ir, ld_pc, ld_led, regw, a_sel, b_sel,
                marmux, pcmux, wb, alu, mem_rd, mem_wr, illegal};

  // Expected observation word; ld_led and marmux_sel are always 0 in this build.
  function automatic logic [23:0] ex(input logic [4:0] st, input logic mar, input logic mdr,
                                     input logic ir, input logic pc, input logic rw,
                                     input logic a, input logic b, input logic pcm,
                                     input logic [1:0] w, input logic [3:0] al,
                                     input logic rd, input logic wr, input logic ill);
    return {st, mar, mdr, ir, pc, 1'b0, rw, a, b, 1'b0, pcm, w, al, rd, wr, ill};
  endfunction

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [23:0] exp;
  } vec_t;

  vec_t tbl[21];

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic wait_state(input logic [4:0] st, input string name);
    int n = 0;
    while (state_dbg !== st && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (state_dbg !== st) begin
      total++;
      $display("FAIL timeout_%s: state %0d expected %0d", name, state_dbg, st);
    end
  endtask

  task automatic step_check(input string name, input logic [23:0] exp);
    @(negedge clk);
    check(name, obs, exp);
  endtask

  initial begin
    //            op     f3      f7    expected first execute cycle
    tbl[0]  = '{7'h33, 3'b000, 7'h00, ex(SRAlu, 0,0,0,1,1, 0,0,0, 2'd1, 4'd0, 0,0,0)};
    tbl[1]  = '{7'h33, 3'b000, 7'h20, ex(SRAlu, 0,0,0,1,1, 0,0,0, 2'd1, 4'd1, 0,0,0)};
    tbl[2]  = '{7'h33, 3'b101, 7'h20, ex(SRAlu, 0,0,0,1,1, 0,0,0, 2'd1, 4'd7, 0,0,0)};
    tbl[3]  = '{7'h33, 3'b011, 7'h00, ex(SRAlu, 0,0,0,1,1, 0,0,0, 2'd1, 4'd4, 0,0,0)};
    tbl[4]  = '{7'h33, 3'b111, 7'h00, ex(SRAlu, 0,0,0,1,1, 0,0,0, 2'd1, 4'd9, 0,0,0)};
    tbl[5]  = '{7'h13, 3'b000, 7'h20, ex(SIAlu, 0,0,0,1,1, 0,1,0, 2'd1, 4'd0, 0,0,0)};
    tbl[6]  = '{7'h13, 3'b101, 7'h20, ex(SIAlu, 0,0,0,1,1, 0,1,0, 2'd1, 4'd7, 0,0,0)};
    tbl[7]  = '{7'h13, 3'b101, 7'h00, ex(SIAlu, 0,0,0,1,1, 0,1,0, 2'd1, 4'd6, 0,0,0)};
    tbl[8]  = '{7'h13, 3'b110, 7'h00, ex(SIAlu, 0,0,0,1,1, 0,1,0, 2'd1, 4'd8, 0,0,0)};
    tbl[9]  = '{7'h13, 3'b010, 7'h00, ex(SIAlu, 0,0,0,1,1, 0,1,0, 2'd1, 4'd3, 0,0,0)};
    tbl[10] = '{7'h13, 3'b100, 7'h00, ex(SIAlu, 0,0,0,1,1, 0,1,0, 2'd1, 4'd5, 0,0,0)};
    tbl[11] = '{7'h13, 3'b001, 7'h00, ex(SIAlu, 0,0,0,1,1, 0,1,0, 2'd1, 4'd2, 0,0,0)};
    tbl[12] = '{7'h03, 3'b010, 7'h00, ex(SLwA,  0,0,0,0,0, 0,1,0, 2'd0, 4'd0, 1,0,0)};
    tbl[13] = '{7'h23, 3'b010, 7'h00, ex(SSw,   0,0,0,0,0, 0,1,0, 2'd0, 4'd0, 0,1,0)};
    tbl[14] = '{7'h63, 3'b000, 7'h00, ex(SBrC,  0,0,0,0,0, 0,0,0, 2'd0, 4'hA, 0,0,0)};
    tbl[15] = '{7'h63, 3'b001, 7'h00, ex(SBrC,  0,0,0,0,0, 0,0,0, 2'd0, 4'hB, 0,0,0)};
    tbl[16] = '{7'h63, 3'b111, 7'h00, ex(SBrC,  0,0,0,0,0, 0,0,0, 2'd0, 4'hF, 0,0,0)};
    tbl[17] = '{7'h63, 3'b100, 7'h00, ex(SBrC,  0,0,0,0,0, 0,0,0, 2'd0, 4'hC, 0,0,0)};
    tbl[18] = '{7'h6F, 3'b000, 7'h00, ex(SJal,  0,0,0,1,1, 1,1,1, 2'd2, 4'd0, 0,0,0)};
    tbl[19] = '{7'h67, 3'b000, 7'h00, ex(SJalr, 0,0,0,1,1, 0,1,1, 2'd2, 4'd0, 0,0,0)};
    tbl[20] = '{7'h17, 3'b000, 7'h00, ex(SAuipc,0,0,0,1,1, 1,1,0, 2'd1, 4'd0, 0,0,0)};

    rst = 1'b1; run = 1'b0; cont = 1'b0; br = 1'b0;
    op = 7'h13; f3 = 3'b000; f7 = 7'h00;
    repeat (2) @(negedge clk);
    check("reset_state", obs, 24'h0);
    rst = 1'b0;
    step_check("halt_idle", 24'h0);

    // ADDI through full fetch with MEM_WAIT=2
    run = 1'b1;
    step_check("fetch1",     ex(SF1,   1,0,0,0,0, 0,0,0, 2'd0, 4'd0, 0,0,0));
    step_check("fetch2_a",   ex(SF2,   0,0,0,0,0, 0,0,0, 2'd0, 4'd0, 1,0,0));
    step_check("fetch2_b",   ex(SF2,   0,1,0,0,0, 0,0,0, 2'd0, 4'd0, 1,0,0));
    step_check("fetch3",     ex(SF3,   0,0,1,0,0, 0,0,0, 2'd0, 4'd0, 0,0,0));
    step_check("decode",     ex(SDec,  0,0,0,0,0, 0,0,0, 2'd0, 4'd0, 0,0,0));
    step_check("addi_exec",  ex(SIAlu, 0,0,0,1,1, 0,1,0, 2'd1, 4'd0, 0,0,0));
    step_check("next_fetch", ex(SF1,   1,0,0,0,0, 0,0,0, 2'd0, 4'd0, 0,0,0));

    for (int i = 0; i < 21; i++) begin
      op = tbl[i].op; f3 = tbl[i].f3; f7 = tbl[i].f7; br = 1'b0;
      wait_state(SDec, $sformatf("dec%0d", i));
      step_check($sformatf("vec%0d", i), tbl[i].exp);
      wait_state(SF1, $sformatf("fetch%0d", i));
    end

    // LW: strobe held exactly MEM_WAIT cycles, selects stable
    op = 7'h03; f3 = 3'b010;
    wait_state(SDec, "lw_dec");
    step_check("lw_addr_a", ex(SLwA,  0,0,0,0,0, 0,1,0, 2'd0, 4'd0, 1,0,0));
    step_check("lw_addr_b", ex(SLwA,  0,0,0,0,0, 0,1,0, 2'd0, 4'd0, 1,0,0));
    step_check("lw_wb",     ex(SLwWb, 0,0,0,1,1, 0,0,0, 2'd0, 4'd0, 0,0,0));
    step_check("lw_done",   ex(SF1,   1,0,0,0,0, 0,0,0, 2'd0, 4'd0, 0,0,0));

    // SW: PC loads only on the last strobe cycle
    op = 7'h23;
    wait_state(SDec, "sw_dec");
    step_check("sw_mem_a", ex(SSw, 0,0,0,0,0, 0,1,0, 2'd0, 4'd0, 0,1,0));
    step_check("sw_mem_b", ex(SSw, 0,0,0,1,0, 0,1,0, 2'd0, 4'd0, 0,1,0));
    step_check("sw_done",  ex(SF1, 1,0,0,0,0, 0,0,0, 2'd0, 4'd0, 0,0,0));

    // Taken BEQ: taken flag must survive br_sig dropping
    op = 7'h63; f3 = 3'b000; br = 1'b1;
    wait_state(SDec, "beq_dec");
    step_check("beq_cmp", ex(SBrC, 0,0,0,0,0, 0,0,0, 2'd0, 4'hA, 0,0,0));
    @(negedge clk);
    br = 1'b0;
    #1 check("beq_tgt", obs, ex(SBrT, 0,0,0,1,0, 1,1,1, 2'd0, 4'd0, 0,0,0));

    // Not-taken BNE, then Run=0 stops at the boundary
    wait_state(SF1, "bne_f1");
    f3 = 3'b001; br = 1'b0;
    wait_state(SDec, "bne_dec");
    step_check("bne_cmp", ex(SBrC, 0,0,0,0,0, 0,0,0, 2'd0, 4'hB, 0,0,0));
    @(negedge clk);
    br = 1'b1; run = 1'b0;
    #1 check("bne_tgt", obs, ex(SBrT, 0,0,0,1,0, 1,1,0, 2'd0, 4'd0, 0,0,0));
    step_check("stop_halt", 24'h0);
    repeat (3) @(negedge clk);
    check("halt_hold", obs, 24'h0);

    // Reset in the middle of FETCH2
    run = 1'b1; op = 7'h13; f3 = 3'b000;
    step_check("rst_f1", ex(SF1, 1,0,0,0,0, 0,0,0, 2'd0, 4'd0, 0,0,0));
    step_check("rst_f2", ex(SF2, 0,0,0,0,0, 0,0,0, 2'd0, 4'd0, 1,0,0));
    rst = 1'b1;
    #1 check("rst_async", obs, 24'h0);
    step_check("rst_hold", 24'h0);
    rst = 1'b0;

    // Illegal branch funct3 traps
    op = 7'h63; f3 = 3'b010;
    wait_state(SDec, "ill_br_dec");
    @(negedge clk);
    step_check("ill_br_trap", ex(STrap, 0,0,0,0,0, 0,0,0, 2'd0, 4'd0, 0,0,1));

    // LUI traps and illegal stays sticky until reset
    rst = 1'b1;
    @(negedge clk);
    check("trap_reset", obs, 24'h0);
    rst = 1'b0; op = 7'h37; f3 = 3'b000;
    wait_state(SDec, "lui_dec");
    step_check("lui_trap", ex(STrap, 0,0,0,0,0, 0,0,0, 2'd0, 4'd0, 0,0,1));
    run = 1'b0; op = 7'h13;
    repeat (4) @(negedge clk);
    check("trap_sticky", obs, ex(STrap, 0,0,0,0,0, 0,0,0, 2'd0, 4'd0, 0,0,1));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
